// File: rtl/serial_addsub.sv
// Bit-serial add/subtract sequencer feeding a single full-adder slice, LSB first.
// Define SERIAL_ADDSUB_FLAGS_EN to build the overflow and zero flag registers.
module serial_addsub #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             overflow,
  output logic             zero
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;

  logic             sum_bit;
  logic             carry_nxt;
  logic             last_bit;
  logic [WIDTH-1:0] result_shifted;

  always_comb begin
    sum_bit        = a_sh_q[0] ^ b_sh_q[0] ^ carry_q;
    carry_nxt      = (a_sh_q[0] & b_sh_q[0]) | (carry_q & (a_sh_q[0] ^ b_sh_q[0]));
    last_bit       = (cnt_q == CNT_W'(WIDTH - 1));
    result_shifted = {sum_bit, result_q[WIDTH-1:1]};
  end

  always_comb begin
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    result_d = result_q;
    cnt_d    = cnt_q;
    carry_d  = carry_q;
    cout_d   = cout_q;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          // Subtraction runs as A + ~B + 1: invert B and seed the carry with 1.
          state_d = RUN;
          a_sh_d  = a;
          b_sh_d  = sub ? ~b : b;
          carry_d = sub;
          cnt_d   = '0;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        a_sh_d   = {1'b0, a_sh_q[WIDTH-1:1]};
        b_sh_d   = {1'b0, b_sh_q[WIDTH-1:1]};
        result_d = result_shifted;
        carry_d  = carry_nxt;
        cnt_d    = cnt_q + 1'b1;
        if (last_bit) begin
          state_d = DONE;
          cout_d  = carry_nxt;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      result_q <= '0;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      cout_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      result_q <= result_d;
      cnt_q    <= cnt_d;
      carry_q  <= carry_d;
      cout_q   <= cout_d;
    end
  end

`ifdef SERIAL_ADDSUB_FLAGS_EN
  logic overflow_q, overflow_d;
  logic zero_q, zero_d;

  // On the MSB step carry_q is the carry into the MSB and carry_nxt the carry out.
  always_comb begin
    overflow_d = overflow_q;
    zero_d     = zero_q;
    if (state_q == RUN && last_bit) begin
      overflow_d = carry_q ^ carry_nxt;
      zero_d     = (result_shifted == '0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_q <= 1'b0;
      zero_q     <= 1'b0;
    end else begin
      overflow_q <= overflow_d;
      zero_q     <= zero_d;
    end
  end

  assign overflow = overflow_q;
  assign zero     = zero_q;
`else
  assign overflow = 1'b0;
  assign zero     = 1'b0;
`endif

  assign busy   = (state_q == RUN);
  assign done   = (state_q == DONE);
  assign result = result_q;
  assign cout   = cout_q;

endmodule

// File: tb/tb_serial_addsub.sv
// Directed self-checking bench for serial_addsub at WIDTH=32 (flag expectations follow SERIAL_ADDSUB_FLAGS_EN).
module tb_serial_addsub;

  localparam int unsigned WIDTH = 32;

`ifdef SERIAL_ADDSUB_FLAGS_EN
  localparam logic FLAGS = 1'b1;
`else
  localparam logic FLAGS = 1'b0;
`endif

  logic             clk;
  logic             rst_n;
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             cout;
  logic             overflow;
  logic             zero;

  int checks = 0;
  int errors = 0;

  serial_addsub #(.WIDTH(WIDTH), .CNT_W(5)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .sub      (sub),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .cout     (cout),
    .overflow (overflow),
    .zero     (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive a one-cycle start; returns just after the accept edge.
  task automatic issue(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv, input logic sv);
    a     = av;
    b     = bv;
    sub   = sv;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_after_accept", {31'd0, busy}, 32'd1);
  endtask

  // Waits (bounded) for done, checking it arrives exactly WIDTH edges after accept.
  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (n < WIDTH + 8) begin
      @(posedge clk); #1;
      n++;
      if (done) break;
    end
    check({tag, "_latency"}, n, WIDTH);
    check({tag, "_busy_at_done"}, {31'd0, busy}, 32'd0);
  endtask

  task automatic check_result(input string tag, input logic [WIDTH-1:0] er, input logic ec,
                              input logic eo, input logic ez);
    check({tag, "_result"}, result, er);
    check({tag, "_cout"}, {31'd0, cout}, {31'd0, ec});
    check({tag, "_ovf"}, {31'd0, overflow}, {31'd0, eo & FLAGS});
    check({tag, "_zero"}, {31'd0, zero}, {31'd0, ez & FLAGS});
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    sub   = 1'b0;
    a     = '0;
    b     = '0;
    #12;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check_result("rst", 32'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 5 + 3
    issue(32'd5, 32'd3, 1'b0);
    wait_done("add5_3");
    check_result("add5_3", 32'd8, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    check("add5_3_done_pulse", {31'd0, done}, 32'd0);
    check("add5_3_idle_busy", {31'd0, busy}, 32'd0);
    check("add5_3_hold", result, 32'd8);

    // Signed overflow on add
    issue(32'h7FFF_FFFF, 32'd1, 1'b0);
    wait_done("add_ovf");
    check_result("add_ovf", 32'h8000_0000, 1'b0, 1'b1, 1'b0);
    @(posedge clk); #1;

    // 3 - 3: zero result, no borrow
    issue(32'd3, 32'd3, 1'b1);
    wait_done("sub3_3");
    check_result("sub3_3", 32'd0, 1'b1, 1'b0, 1'b1);
    @(posedge clk); #1;

    // 0 - 1: borrow
    issue(32'd0, 32'd1, 1'b1);
    wait_done("sub0_1");
    check_result("sub0_1", 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;

    // start during RUN is ignored; start in DONE is accepted back-to-back
    issue(32'd10, 32'd20, 1'b0);
    repeat (9) begin @(posedge clk); #1; end
    a     = 32'd1;
    b     = 32'd1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("ignore_busy", {31'd0, busy}, 32'd1);
    begin
      int n;
      n = 10;
      while (n < WIDTH + 8) begin
        @(posedge clk); #1;
        n++;
        if (done) break;
      end
      check("ignore_latency", n, WIDTH);
    end
    check_result("ignore", 32'd30, 1'b0, 1'b0, 1'b0);
    a     = 32'd1;
    b     = 32'd1;
    sub   = 1'b0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("b2b_done_fall", {31'd0, done}, 32'd0);
    check("b2b_busy", {31'd0, busy}, 32'd1);
    wait_done("b2b");
    check_result("b2b", 32'd2, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;

    // Asynchronous reset in the middle of RUN
    issue(32'h1234_5678, 32'h1111_1111, 1'b0);
    repeat (15) begin @(posedge clk); #1; end
    check("pre_rst_busy", {31'd0, busy}, 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_done", {31'd0, done}, 32'd0);
    check("mid_rst_result", result, 32'd0);
    check("mid_rst_cout", {31'd0, cout}, 32'd0);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_idle", {31'd0, busy}, 32'd0);
    issue(32'd7, 32'd9, 1'b0);
    wait_done("post_rst");
    check_result("post_rst", 32'd16, 1'b0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
